// File: rtl/priority_codec_pkg.sv
// Shared definitions for the priority encoder / decoder pair: word and
// index widths, the decoder collection states and a 16-bit popcount.
package priority_codec_pkg;

  localparam int WIDTH = 16;
  localparam int IDX_W = 4;
  localparam int CNT_W = 5;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_e;

  // Number of set bits in a 16-bit word, 0..16.
  function automatic logic [CNT_W-1:0] popcount16(input logic [WIDTH-1:0] word);
    logic [CNT_W-1:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + {4'd0, word[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/priority_decoder.sv
// Rebuilds a 16-bit word from an MSB-first stream of set-bit indices.
// Reports the first index seen, the popcount, and sticky duplicate /
// ordering violations; hands finished words out through a registered
// valid/ready stage that back-pressures the input while occupied.
module priority_decoder
  import priority_codec_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_index,
  input  logic             in_empty,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic [IDX_W-1:0] out_msb,
  output logic [CNT_W-1:0] out_count,
  output logic             out_dup,
  output logic             out_order_err
);

  state_e             state_r;
  state_e             state_nxt_s;
  logic [WIDTH-1:0]   acc_word_r;
  logic [IDX_W-1:0]   first_idx_r;
  logic [IDX_W-1:0]   prev_idx_r;
  logic               dup_r;
  logic               order_err_r;

  // Accumulator as it would look with the current beat folded in.
  state_e             merged_state_s;
  logic [WIDTH-1:0]   merged_word_s;
  logic [IDX_W-1:0]   merged_first_s;
  logic [IDX_W-1:0]   merged_prev_s;
  logic               merged_dup_s;
  logic               merged_order_s;

  logic               in_ready_s;
  logic               accept_s;
  logic               beat_set_s;
  logic               word_done_s;
  logic [WIDTH-1:0]   idx_onehot_s;

  logic               out_valid_r;
  logic [WIDTH-1:0]   out_word_r;
  logic [IDX_W-1:0]   out_msb_r;
  logic [CNT_W-1:0]   out_count_r;
  logic               out_dup_r;
  logic               out_order_err_r;

  // A held word blocks new beats until downstream takes it.
  assign in_ready_s   = !out_valid_r || out_ready;
  assign accept_s     = in_valid && in_ready_s;
  assign beat_set_s   = accept_s && !in_empty;
  assign word_done_s  = accept_s && in_last;
  assign idx_onehot_s = 16'd1 << in_index;

  // Fold the accepted beat into a copy of the accumulator and pick the next state.
  always_comb begin
    merged_state_s = state_r;
    merged_word_s  = acc_word_r;
    merged_first_s = first_idx_r;
    merged_prev_s  = prev_idx_r;
    merged_dup_s   = dup_r;
    merged_order_s = order_err_r;
    if (beat_set_s) begin
      merged_word_s = acc_word_r | idx_onehot_s;
      merged_prev_s = in_index;
      if ((acc_word_r & idx_onehot_s) != 16'd0) begin
        merged_dup_s = 1'b1;
      end else begin
        merged_dup_s = dup_r;
      end
      case (state_r)
        ST_IDLE: begin
          merged_first_s = in_index;
          merged_state_s = ST_COLLECT;
        end
        ST_COLLECT: begin
          if (in_index >= prev_idx_r) begin
            merged_order_s = 1'b1;
          end else begin
            merged_order_s = order_err_r;
          end
        end
        default: begin
          merged_state_s = ST_IDLE;
        end
      endcase
    end else begin
      merged_word_s = acc_word_r;
    end
    if (word_done_s) begin
      state_nxt_s = ST_IDLE;
    end else begin
      state_nxt_s = merged_state_s;
    end
  end

  // Collection state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Accumulator: absorbs beats, clears when a word is handed off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_word_r  <= 16'd0;
      first_idx_r <= 4'd0;
      prev_idx_r  <= 4'd0;
      dup_r       <= 1'b0;
      order_err_r <= 1'b0;
    end else if (word_done_s) begin
      acc_word_r  <= 16'd0;
      first_idx_r <= 4'd0;
      prev_idx_r  <= 4'd0;
      dup_r       <= 1'b0;
      order_err_r <= 1'b0;
    end else begin
      acc_word_r  <= merged_word_s;
      first_idx_r <= merged_first_s;
      prev_idx_r  <= merged_prev_s;
      dup_r       <= merged_dup_s;
      order_err_r <= merged_order_s;
    end
  end

  // Output stage: loads on the last beat, holds until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r     <= 1'b0;
      out_word_r      <= 16'd0;
      out_msb_r       <= 4'd0;
      out_count_r     <= 5'd0;
      out_dup_r       <= 1'b0;
      out_order_err_r <= 1'b0;
    end else if (word_done_s) begin
      out_valid_r     <= 1'b1;
      out_word_r      <= merged_word_s;
      out_msb_r       <= merged_first_s;
      out_count_r     <= popcount16(merged_word_s);
      out_dup_r       <= merged_dup_s;
      out_order_err_r <= merged_order_s;
    end else if (out_ready) begin
      out_valid_r     <= 1'b0;
    end else begin
      out_valid_r     <= out_valid_r;
    end
  end

  assign in_ready      = in_ready_s;
  assign out_valid     = out_valid_r;
  assign out_word      = out_word_r;
  assign out_msb       = out_msb_r;
  assign out_count     = out_count_r;
  assign out_dup       = out_dup_r;
  assign out_order_err = out_order_err_r;

endmodule

// File: tb/tb_priority_decoder.sv
// Bench for priority_decoder: directed words from the test plan plus a
// randomized stream checked against a per-word reference model.
module tb_priority_decoder;
  import priority_codec_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_index;
  logic        in_empty;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_word;
  logic [3:0]  out_msb;
  logic [4:0]  out_count;
  logic        out_dup;
  logic        out_order_err;

  int checks = 0;
  int fails  = 0;

  typedef struct packed {
    logic [1:0]  n;
    logic [11:0] idxs;
    logic [2:0]  emps;
    logic [15:0] w;
    logic [3:0]  msb;
    logic [4:0]  cnt;
    logic        dup;
    logic        ord;
  } dcase_t;

  typedef struct packed {
    logic [15:0] w;
    logic [3:0]  msb;
    logic [4:0]  cnt;
    logic        dup;
    logic        ord;
  } exp_t;

  priority_decoder dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_index(in_index),
    .in_empty(in_empty), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_msb(out_msb), .out_count(out_count), .out_dup(out_dup),
    .out_order_err(out_order_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer one beat and hold it until accepted (bounded wait).
  task automatic send_beat(input logic [3:0] idx, input logic emp, input logic lst);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_index = idx; in_empty = emp; in_last = lst;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; fails++;
      $display("FAIL send_beat_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_index = 4'd0; in_empty = 1'b0;
    in_last = 1'b0; out_ready = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_word, out_msb, out_count, out_dup, out_order_err} !== 28'd0) begin
      fails++;
      $display("FAIL reset_outputs: got valid=%0b word=%h msb=%0d cnt=%0d dup=%0b ord=%0b, required all 0",
               out_valid, out_word, out_msb, out_count, out_dup, out_order_err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %0b required 1", in_ready);
    end
  endtask

  task automatic test_directed_words();
    dcase_t tbl[4];
    tbl[0] = '{n:2'd3, idxs:{4'd0, 4'd7, 4'd15}, emps:3'b000, w:16'h8081, msb:4'd15, cnt:5'd3, dup:1'b0, ord:1'b0};
    tbl[1] = '{n:2'd1, idxs:12'd0, emps:3'b001, w:16'h0000, msb:4'd0, cnt:5'd0, dup:1'b0, ord:1'b0};
    tbl[2] = '{n:2'd2, idxs:{4'd0, 4'd9, 4'd9}, emps:3'b000, w:16'h0200, msb:4'd9, cnt:5'd1, dup:1'b1, ord:1'b1};
    tbl[3] = '{n:2'd2, idxs:{4'd0, 4'd12, 4'd3}, emps:3'b000, w:16'h1008, msb:4'd3, cnt:5'd2, dup:1'b0, ord:1'b1};
    out_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < int'(tbl[t].n); k++) begin
        send_beat(tbl[t].idxs[k*4 +: 4], tbl[t].emps[k], (k == int'(tbl[t].n) - 1));
      end
      checks++;
      if (out_valid !== 1'b1) begin
        fails++;
        $display("FAIL word%0d_valid: got %0b required 1", t, out_valid);
      end
      checks++;
      if ({out_word, out_msb, out_count, out_dup, out_order_err} !==
          {tbl[t].w, tbl[t].msb, tbl[t].cnt, tbl[t].dup, tbl[t].ord}) begin
        fails++;
        $display("FAIL word%0d_fields: got word=%h msb=%0d cnt=%0d dup=%0b ord=%0b, required word=%h msb=%0d cnt=%0d dup=%0b ord=%0b",
                 t, out_word, out_msb, out_count, out_dup, out_order_err,
                 tbl[t].w, tbl[t].msb, tbl[t].cnt, tbl[t].dup, tbl[t].ord);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL word%0d_valid_one_cycle: got %0b required 0", t, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send_beat(4'd5, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b1; in_index = 4'd4; in_empty = 1'b0; in_last = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({in_ready, out_valid, out_word} !== {1'b0, 1'b1, 16'h0020}) begin
        fails++;
        $display("FAIL stall_c%0d: got in_ready=%0b valid=%0b word=%h, required 0 1 0020",
                 c, in_ready, out_valid, out_word);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL stall_release: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if ({out_valid, out_word, out_msb, out_count} !== {1'b1, 16'h0010, 4'd4, 5'd1}) begin
      fails++;
      $display("FAIL word_b: got valid=%0b word=%h msb=%0d cnt=%0d, required 1 0010 4 1",
               out_valid, out_word, out_msb, out_count);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL word_b_drain: out_valid=%0b required 0", out_valid);
    end
  endtask

  task automatic test_reset_midword();
    out_ready = 1'b0;
    send_beat(4'd5, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_word} !== 17'd0) begin
      fails++;
      $display("FAIL reset_drops_held: got valid=%0b word=%h required 0 0000", out_valid, out_word);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send_beat(4'd14, 1'b0, 1'b0);
    send_beat(4'd2, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send_beat(4'd1, 1'b0, 1'b1);
    checks++;
    if ({out_valid, out_word, out_msb, out_count, out_dup, out_order_err} !==
        {1'b1, 16'h0002, 4'd1, 5'd1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_midword: got valid=%0b word=%h msb=%0d cnt=%0d dup=%0b ord=%0b, required 1 0002 1 1 0 0",
               out_valid, out_word, out_msb, out_count, out_dup, out_order_err);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int   cur[$];
    exp_t exp_q[$];
    exp_t e;
    bit   pend;
    bit   desc;
    bit   hs_in;
    bit   hs_out;
    bit   seen[16];
    bit   got_first;
    int   prev;
    int   lim;
    pend = 1'b0;
    desc = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      out_ready = ($urandom_range(3, 0) != 0);
      if (!pend) begin
        if ($urandom_range(3, 0) != 0) begin
          pend = 1'b1;
          in_valid = 1'b1;
          in_empty = ($urandom_range(7, 0) == 0);
          in_last  = ($urandom_range(4, 0) == 0);
          if (desc) begin
            lim = 15;
            foreach (cur[k]) if (cur[k] >= 0) lim = cur[k] - 1;
            if (lim < 0) begin
              in_empty = 1'b1;
              in_last  = 1'b1;
              in_index = 4'($urandom_range(15, 0));
            end else begin
              in_index = 4'($urandom_range(lim, 0));
            end
          end else begin
            in_index = 4'($urandom_range(15, 0));
          end
        end else begin
          in_valid = 1'b0;
        end
      end
      #1;
      hs_out = (exp_q.size() != 0) && out_ready;
      hs_in  = in_valid && ((exp_q.size() == 0) || out_ready);
      checks++;
      if (out_valid !== (exp_q.size() != 0)) begin
        fails++;
        $display("FAIL rnd_valid cyc%0d: got %0b required %0b", cyc, out_valid, exp_q.size() != 0);
      end
      checks++;
      if (in_ready !== ((exp_q.size() == 0) || out_ready)) begin
        fails++;
        $display("FAIL rnd_in_ready cyc%0d: got %0b required %0b", cyc, in_ready,
                 (exp_q.size() == 0) || out_ready);
      end
      if (hs_out) begin
        checks++;
        if ({out_word, out_msb, out_count, out_dup, out_order_err} !== exp_q[0]) begin
          fails++;
          $display("FAIL rnd_word cyc%0d: got word=%h msb=%0d cnt=%0d dup=%0b ord=%0b, required word=%h msb=%0d cnt=%0d dup=%0b ord=%0b",
                   cyc, out_word, out_msb, out_count, out_dup, out_order_err,
                   exp_q[0].w, exp_q[0].msb, exp_q[0].cnt, exp_q[0].dup, exp_q[0].ord);
        end
        void'(exp_q.pop_front());
      end
      if (hs_in) begin
        cur.push_back(in_empty ? -1 : int'(in_index));
        pend = 1'b0;
        if (in_last) begin
          e = '0;
          foreach (seen[b]) seen[b] = 1'b0;
          got_first = 1'b0;
          prev = -1;
          foreach (cur[k]) begin
            if (cur[k] >= 0) begin
              if (seen[cur[k]]) e.dup = 1'b1;
              seen[cur[k]] = 1'b1;
              e.w[cur[k]] = 1'b1;
              if (got_first && cur[k] >= prev) e.ord = 1'b1;
              if (!got_first) e.msb = 4'(cur[k]);
              got_first = 1'b1;
              prev = cur[k];
            end
          end
          foreach (seen[b]) if (seen[b]) e.cnt = e.cnt + 5'd1;
          exp_q.push_back(e);
          cur.delete();
          desc = ($urandom_range(1, 0) == 1);
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed_words();
    test_backpressure();
    test_reset_midword();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
